// File: rtl/mult_result_queue.sv
// mult_result_queue
// Output stage for the sequential multiplier. It registers the FSM status
// lines and holds the last product on result/done between operations.
// Every completed product is also buffered in a first-word-fall-through
// queue that a valid/ready consumer (display, UART) drains.
module mult_result_queue #(
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 3,
    parameter int DEPTH      = 4,
    parameter int DONE_PULSE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           sig_resultado,
    input  logic                       sig_done,
    input  logic                       sig_estado,
    input  logic [1:0]                 sig_temp,
    input  logic [CNT_W-1:0]           sig_contador,
    input  logic                       valid,
    input  logic                       clear_output,
    input  logic                       q_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       done,
    output logic                       estado_actual,
    output logic [1:0]                 temp,
    output logic [CNT_W-1:0]           contador,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q_data,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] retained_value;
    logic             retained_flag;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             overflow_q;

    logic push_req;
    logic push_ok;
    logic pop;
    logic full;

    // A completed product is offered to the queue unless valid or clear_output
    // override it; a full queue still accepts it when the head leaves this cycle.
    always_comb begin
        push_req = sig_done && !valid && !clear_output;
        full     = (occupancy == OCC_W'(DEPTH));
        pop      = q_valid && q_ready;
        push_ok  = push_req && (!full || pop);
    end

    assign q_valid  = (occupancy != '0);
    assign q_data   = mem[rd_ptr];
    assign q_count  = occupancy;
    assign overflow = overflow_q;

    // Status mirrors simply follow the controller one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_actual <= 1'b0;
            temp          <= '0;
            contador      <= '0;
        end else begin
            estado_actual <= sig_estado;
            temp          <= sig_temp;
            contador      <= sig_contador;
        end
    end

    // Result/done path: clear and valid wipe the retained product, a finished
    // product is latched, and while idle the retained product is replayed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result         <= '0;
            done           <= 1'b0;
            retained_value <= '0;
            retained_flag  <= 1'b0;
        end else if (clear_output || valid) begin
            result         <= '0;
            done           <= 1'b0;
            retained_value <= '0;
            retained_flag  <= 1'b0;
        end else if (sig_done) begin
            result         <= sig_resultado;
            done           <= 1'b1;
            retained_value <= sig_resultado;
            retained_flag  <= 1'b1;
        end else if (!estado_actual) begin
            result <= retained_value;
            done   <= (DONE_PULSE != 0) ? 1'b0 : retained_flag;
        end else begin
            result <= sig_resultado;
            done   <= 1'b0;
        end
    end

    // Queue storage and pointers; clear_output empties the queue but leaves
    // stale words in storage since they are never visible while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            overflow_q <= 1'b0;
        end else if (clear_output) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= sig_resultado;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_queue.sv
// tb_mult_result_queue
// Randomised and directed stimulus for mult_result_queue with a scoreboard:
// accepted products go into an expected queue, and a monitor compares every
// consumer handshake against its head. A second instance in pulsed-done mode
// shares the same inputs.
module tb_mult_result_queue;

    localparam int WIDTH = 16;
    localparam int CNT_W = 3;
    localparam int DEPTH = 4;
    localparam int QW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sig_resultado;
    logic             sig_done;
    logic             sig_estado;
    logic [1:0]       sig_temp;
    logic [CNT_W-1:0] sig_contador;
    logic             valid;
    logic             clear_output;
    logic             q_ready;

    logic [WIDTH-1:0] result;
    logic             done;
    logic             estado_actual;
    logic [1:0]       temp;
    logic [CNT_W-1:0] contador;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic [QW-1:0]    q_count;
    logic             overflow;

    logic [WIDTH-1:0] result_p;
    logic             done_p;
    logic             estado_p;
    logic [1:0]       temp_p;
    logic [CNT_W-1:0] contador_p;
    logic             q_valid_p;
    logic [WIDTH-1:0] q_data_p;
    logic [QW-1:0]    q_count_p;
    logic             overflow_p;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_result;
    logic             m_done;
    logic             m_done_p;
    logic [WIDTH-1:0] m_ret;
    logic             m_flag;
    logic             m_estado;
    logic [1:0]       m_temp;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovf;

    mult_result_queue #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH), .DONE_PULSE(0)) dut (
        .clk(clk), .rst(rst_n), .sig_resultado(sig_resultado), .sig_done(sig_done),
        .sig_estado(sig_estado), .sig_temp(sig_temp), .sig_contador(sig_contador),
        .valid(valid), .clear_output(clear_output), .q_ready(q_ready),
        .result(result), .done(done), .estado_actual(estado_actual), .temp(temp),
        .contador(contador), .q_valid(q_valid), .q_data(q_data), .q_count(q_count),
        .overflow(overflow)
    );

    mult_result_queue #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH), .DONE_PULSE(1)) dut_pulse (
        .clk(clk), .rst(rst_n), .sig_resultado(sig_resultado), .sig_done(sig_done),
        .sig_estado(sig_estado), .sig_temp(sig_temp), .sig_contador(sig_contador),
        .valid(valid), .clear_output(clear_output), .q_ready(q_ready),
        .result(result_p), .done(done_p), .estado_actual(estado_p), .temp(temp_p),
        .contador(contador_p), .q_valid(q_valid_p), .q_data(q_data_p), .q_count(q_count_p),
        .overflow(overflow_p)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareValue(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Consumer monitor: every handshake must return the oldest accepted product
    always @(negedge clk) begin
        if (rst_n && q_valid && q_ready) begin
            if (exp_q.size() == 0) begin
                compareValue("q_pop_unexpected", 32'(q_count), 32'd0);
            end else begin
                compareValue("q_pop_data", 32'(q_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic modelReset();
        exp_q.delete();
        m_result = '0;
        m_done   = 1'b0;
        m_done_p = 1'b0;
        m_ret    = '0;
        m_flag   = 1'b0;
        m_estado = 1'b0;
        m_temp   = '0;
        m_cnt    = '0;
        m_ovf    = 1'b0;
    endtask

    // What one rising edge should do given the inputs the bench is driving
    task automatic modelEdge();
        if (clear_output || valid) begin
            m_result = '0;
            m_done   = 1'b0;
            m_done_p = 1'b0;
            m_ret    = '0;
            m_flag   = 1'b0;
        end else if (sig_done) begin
            m_result = sig_resultado;
            m_ret    = sig_resultado;
            m_done   = 1'b1;
            m_done_p = 1'b1;
            m_flag   = 1'b1;
        end else if (!m_estado) begin
            m_result = m_ret;
            m_done   = m_flag;
            m_done_p = 1'b0;
        end else begin
            m_result = sig_resultado;
            m_done   = 1'b0;
            m_done_p = 1'b0;
        end
        if (clear_output) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else if (sig_done && !valid) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(sig_resultado);
            else m_ovf = 1'b1;
        end
        m_estado = sig_estado;
        m_temp   = sig_temp;
        m_cnt    = sig_contador;
    endtask

    task automatic checkOutput();
        compareValue("result", 32'(result), 32'(m_result));
        compareValue("done", 32'(done), 32'(m_done));
        compareValue("result_pulse", 32'(result_p), 32'(m_result));
        compareValue("done_pulse", 32'(done_p), 32'(m_done_p));
        compareValue("estado_actual", 32'(estado_actual), 32'(m_estado));
        compareValue("temp", 32'(temp), 32'(m_temp));
        compareValue("contador", 32'(contador), 32'(m_cnt));
        compareValue("q_count", 32'(q_count), 32'(exp_q.size()));
        compareValue("q_valid", 32'(q_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
        compareValue("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() != 0) compareValue("q_head", 32'(q_data), 32'(exp_q[0]));
    endtask

    task automatic checkResetState();
        compareValue("rst_result", 32'(result), 32'd0);
        compareValue("rst_done", 32'(done), 32'd0);
        compareValue("rst_estado", 32'(estado_actual), 32'd0);
        compareValue("rst_temp", 32'(temp), 32'd0);
        compareValue("rst_contador", 32'(contador), 32'd0);
        compareValue("rst_q_valid", 32'(q_valid), 32'd0);
        compareValue("rst_q_data", 32'(q_data), 32'd0);
        compareValue("rst_q_count", 32'(q_count), 32'd0);
        compareValue("rst_overflow", 32'(overflow), 32'd0);
        compareValue("rst_done_pulse", 32'(done_p), 32'd0);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare
    task automatic applyStimulus(input logic [WIDTH-1:0] sr, input logic sd, input logic est,
                                 input logic vld, input logic clr, input logic rdy);
        sig_resultado = sr;
        sig_done      = sd;
        sig_estado    = est;
        sig_temp      = 2'($urandom);
        sig_contador  = CNT_W'($urandom);
        valid         = vld;
        clear_output  = clr;
        q_ready       = rdy;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic est, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(WIDTH'($urandom), 1'b0, est, 1'b0, 1'b0, rdy);
    endtask

    task automatic pushValue(input logic [WIDTH-1:0] v, input logic rdy);
        applyStimulus(v, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic randomInputs();
        sig_resultado = WIDTH'($urandom);
        sig_done      = 1'($urandom);
        sig_estado    = 1'($urandom);
        sig_temp      = 2'($urandom);
        sig_contador  = CNT_W'($urandom);
        valid         = 1'($urandom);
        clear_output  = 1'($urandom);
        q_ready       = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        randomInputs();
        modelReset();

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetState();
            randomInputs();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();

        // Single product, then idle: result holds, sticky vs pulsed done
        applyStimulus(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        applyStimulus(16'hFFEB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0, 1'b0);
        compareValue("hold_result", 32'(result), 32'h0000FFEB);
        compareValue("hold_q_data", 32'(q_data), 32'h0000FFEB);

        // valid clears result/done but not the queue; valid beats sig_done
        applyStimulus(WIDTH'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);

        // Fill past capacity then drain
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int v = 1; v <= 5; v++) pushValue(WIDTH'(v), 1'b0);
        idle(5, 1'b0, 1'b1);

        // Full queue with simultaneous push and pop, draining across the wrap
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b1);
        for (int v = 1; v <= 4; v++) pushValue(WIDTH'(v), 1'b0);
        pushValue(16'd9, 1'b1);
        idle(5, 1'b0, 1'b1);

        // clear_output with three entries and overflow set, plus a discarded push
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int v = 1; v <= 5; v++) pushValue(WIDTH'(v), 1'b0);
        idle(1, 1'b1, 1'b1);
        applyStimulus(16'h0077, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(WIDTH'($urandom),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 39) == 0),
                          1'($urandom));
        end

        // Reset asserted mid-cycle with a populated queue
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int v = 1; v <= 3; v++) pushValue(WIDTH'(v + 100), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState();
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
